word_lane_serializer: RTL and testbench
=======================================

# word_lane_serializer

Downstream consumer of the wide data bus produced by the top-level lane array. Captures one `PAR_GLB_DATA_BITS`-wide word through a valid/ready handshake and emits it as a stream of 16-bit lanes, one per accepted beat, with a last-lane marker. It feeds the narrow 16-bit egress path and supports back-to-back words with no bubble cycle.

## Interface

Parameters:
- `PAR_DATA_BITS`, default `` `PAR_GLB_DATA_BITS ``: input word width. Must be a multiple of 16 and at least 32.
- `PAR_LANE_BITS`, default 16: lane width. Fixed at 16; any other value is unsupported.
- Derived constant `N = PAR_DATA_BITS/16`: lanes per word.

Ports:
- `ib_clk` in 1: sole clock, rising edge.
- `ib_rst` in 1: asynchronous, active-low reset. Assertion is asynchronous; release is assumed synchronous to `ib_clk`.
- `ivG_data` in `PAR_DATA_BITS`: input word.
- `ib_valid` in 1: input word valid.
- `ob_ready` out 1: block can accept a word this cycle.
- `ovG_lane` out 16: current output lane.
- `ob_valid` out 1: `ovG_lane` is valid.
- `ib_ready` in 1: downstream accepts the lane this cycle.
- `ob_last` out 1: current lane is lane N-1 of its word.
- `ovG_index` out `$clog2(N)`: index of the lane currently presented.

## Operation

- A handshake occurs on any rising edge where valid and ready are both 1.
- The FSM has two states:
  - IDLE: `ob_valid`=0 and `ob_ready`=1.
  - SEND: the word is held in a `PAR_DATA_BITS` register `r_word`, and lane counter `r_idx` runs 0..N-1.
- Transitions:
  - IDLE → SEND on input handshake: capture `ivG_data` into `r_word`, clear `r_idx` to 0.
  - SEND, output handshake with `r_idx`<N-1: increment `r_idx`.
  - SEND, output handshake with `r_idx`=N-1 and `ib_valid`=1: capture the new word, set `r_idx`=0, stay in SEND (back-to-back).
  - SEND, output handshake with `r_idx`=N-1 and `ib_valid`=0: go to IDLE.
  - SEND, no output handshake: hold everything. `ovG_lane`, `ob_last` and `ovG_index` are stable while `ob_valid`=1 and `ib_ready`=0.
- `ob_ready` = (state==IDLE) OR (state==SEND AND `r_idx`==N-1 AND `ib_ready`). This is the only combinational path, from `ib_ready` to `ob_ready`.
- `ovG_lane` = `r_word[16*k+15 : 16*k]`, where k is the lane selected by `r_idx` (order per Configuration).
- `ob_last` = `ob_valid` AND (`r_idx`==N-1).
- `ivG_data` is sampled only on an input handshake. Changes at any other time have no effect.
- `ib_valid` and `ib_ready` are both allowed to toggle freely. The block never drops or duplicates a lane.

## Timing

- Reset values:
  - state = IDLE, `r_word` = 0, `r_idx` = 0.
  - `ob_valid` = 0, `ob_last` = 0, `ovG_lane` = 0, `ovG_index` = 0.
  - `ob_ready` = 1 (follows IDLE).
- Latency: a word accepted at edge k presents lane 0 with `ob_valid`=1 after edge k (cycle k+1).
- Throughput: exactly N cycles per word with `ib_ready` held at 1. Consecutive words have no idle cycle between them.
- Reset mid-word: the partially sent word is discarded. Outputs go to their reset values immediately (asynchronously). After release, the first handshake starts a fresh word at lane 0.
- A single edge that carries both the last-lane output handshake and an input handshake loads the new word. Lane 0 of the new word is presented in the next cycle.

## Configuration

- `` `SER_MSB_FIRST_EN `` defined: lane k = `r_word[16*(N-1-k)+15 : 16*(N-1-k)]`, so the most significant lane is sent first.
- `` `SER_MSB_FIRST_EN `` undefined (default): lane k = `r_word[16*k+15 : 16*k]`, so the least significant lane is sent first.
- All handshake and timing behaviour is identical in both builds; only lane order changes.

## Test plan

All scenarios use `PAR_DATA_BITS`=64 (N=4).

- **Reset:** hold `ib_rst`=0 for 3 cycles → `ob_valid`=0, `ovG_lane`=16'h0000, `ob_ready`=1. Releasing reset changes none of these outputs.
- **Single word:** with `ib_ready`=1, send 64'h4444_3333_2222_1111 → lanes 1111, 2222, 3333, 4444 on consecutive cycles, `ob_last`=1 only with 4444, then `ob_valid`=0.
  - With `SER_MSB_FIRST_EN`: order 4444, 3333, 2222, 1111.
- **Back-to-back:** keep `ib_valid`=1 with words A=64'hA3A2_A1A0_0000_0000+… and B, `ib_ready`=1 → 8 consecutive valid lanes with no gap. `ob_ready` pulses only on the cycle lane 3 of A is accepted.
- **Backpressure:** drop `ib_ready` to 0 for 5 cycles while lane 2222 is presented → `ovG_lane`=2222, `ovG_index`=1 and `ob_valid`=1 stay stable. The stream then resumes with 3333, and no lane is lost or repeated.
- **Reset mid-word:** assert `ib_rst` after lane 2222 is accepted → `ob_valid` drops immediately. The next word 64'hDDDD_CCCC_BBBB_AAAA is output starting at AAAA.
- **Input ignored while busy:** change `ivG_data` with `ib_valid`=1 while lanes 0..2 are sending → the output lanes are unchanged, and `ob_ready` stays 0 until the lane 3 handshake.

Source files
------------

// File: rtl/word_lane_serializer.sv
// word_lane_serializer: captures one wide word through a valid/ready handshake
// and replays it as a stream of 16-bit lanes with a last-lane marker. The
// input is re-armed during the final lane so consecutive words flow without a
// bubble cycle.
// Optional feature macro: SER_MSB_FIRST_EN (send the most significant lane
// first); undefined by default, which sends the least significant lane first.

`ifndef PAR_GLB_DATA_BITS
`define PAR_GLB_DATA_BITS 64
`endif

module word_lane_serializer #(
    parameter int unsigned PAR_DATA_BITS = `PAR_GLB_DATA_BITS,
    parameter int unsigned PAR_LANE_BITS = 16
) (
    input  logic                                   ib_clk,
    input  logic                                   ib_rst,
    input  logic [PAR_DATA_BITS-1:0]               ivG_data,
    input  logic                                   ib_valid,
    output logic                                   ob_ready,
    output logic [PAR_LANE_BITS-1:0]               ovG_lane,
    output logic                                   ob_valid,
    input  logic                                   ib_ready,
    output logic                                   ob_last,
    output logic [$clog2(PAR_DATA_BITS/PAR_LANE_BITS)-1:0] ovG_index
);

    localparam int unsigned N     = PAR_DATA_BITS / PAR_LANE_BITS;
    localparam int unsigned IDX_W = $clog2(N);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [PAR_DATA_BITS-1:0] r_word_q, r_word_d;
    logic [IDX_W-1:0]         r_idx_q, r_idx_d;

    logic                     idx_last;
    logic                     out_hs;
    logic [IDX_W-1:0]         lane_sel;
    logic [PAR_LANE_BITS-1:0] lanes [N];

    // Lane view of the held word, lane i occupying bits [16*i +: 16].
    for (genvar gi = 0; gi < int'(N); gi++) begin : g_lanes
        assign lanes[gi] = r_word_q[gi*int'(PAR_LANE_BITS) +: PAR_LANE_BITS];
    end

    // Map the running lane counter onto a physical lane of the word.
`ifdef SER_MSB_FIRST_EN
    assign lane_sel = IDX_W'(N - 1) - r_idx_q;
`else
    assign lane_sel = r_idx_q;
`endif

    // State, word and lane counter registers.
    always_ff @(posedge ib_clk or negedge ib_rst) begin
        if (!ib_rst) begin
            state_q  <= ST_IDLE;
            r_word_q <= '0;
            r_idx_q  <= '0;
        end else begin
            state_q  <= state_d;
            r_word_q <= r_word_d;
            r_idx_q  <= r_idx_d;
        end
    end

    // Next-state logic plus the ib_ready -> ob_ready pass-through.
    always_comb begin
        state_d  = state_q;
        r_word_d = r_word_q;
        r_idx_d  = r_idx_q;
        ob_ready = 1'b0;
        idx_last = (r_idx_q == IDX_W'(N - 1));
        out_hs   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ob_ready = 1'b1;
                if (ib_valid) begin
                    r_word_d = ivG_data;
                    r_idx_d  = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                out_hs   = ib_ready;
                ob_ready = idx_last && ib_ready;
                if (out_hs) begin
                    if (!idx_last) begin
                        r_idx_d = r_idx_q + IDX_W'(1);
                    end else if (ib_valid) begin
                        // Last lane leaves while a new word arrives: reload.
                        r_word_d = ivG_data;
                        r_idx_d  = '0;
                    end else begin
                        r_idx_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output presentation is decoded straight from the registers.
    always_comb begin
        ob_valid  = (state_q == ST_SEND);
        ob_last   = ob_valid && idx_last;
        ovG_index = r_idx_q;
        ovG_lane  = lanes[lane_sel];
    end

endmodule

// File: tb/tb_word_lane_serializer.sv
// Directed bench for word_lane_serializer with a 64-bit word (four lanes).
`timescale 1ns/1ps

module tb_word_lane_serializer;

    logic        clk;
    logic        rst_n;
    logic [63:0] data;
    logic        in_valid;
    logic        out_ready_dn;
    logic        ob_ready;
    logic [15:0] lane;
    logic        ob_valid;
    logic        ob_last;
    logic [1:0]  index;

    int n_cmp  = 0;
    int n_fail = 0;

    word_lane_serializer #(
        .PAR_DATA_BITS(64),
        .PAR_LANE_BITS(16)
    ) dut (
        .ib_clk   (clk),
        .ib_rst   (rst_n),
        .ivG_data (data),
        .ib_valid (in_valid),
        .ob_ready (ob_ready),
        .ovG_lane (lane),
        .ob_valid (ob_valid),
        .ib_ready (out_ready_dn),
        .ob_last  (ob_last),
        .ovG_index(index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {valid, last, ready, index, lane}
    wire [20:0] obs = {ob_valid, ob_last, ob_ready, index, lane};

    // Expected lane k of a word, in transmission order.
    function automatic logic [15:0] lane_of(input logic [63:0] w, input int k);
        logic [63:0] t;
        t = w;
`ifdef SER_MSB_FIRST_EN
        return t[16*(3-k) +: 16];
`else
        return t[16*k +: 16];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready_dn = 1'b0; data = '0;
        repeat (3) tick();
        e = {1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", obs, e);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs, e);
        end
    endtask

    task automatic test_single_word();
        logic [63:0] w;
        logic [20:0] e;
        w = 64'h4444_3333_2222_1111;
        data = w; in_valid = 1'b1; out_ready_dn = 1'b1;
        #1;
        n_cmp++;
        if (ob_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_ready: got %b want 1", ob_ready);
        end
        tick();
        in_valid = 1'b0; data = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = {1'b1, (k == 3), (k == 3), 2'(k), lane_of(w, k)};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single_lane%0d: got %h want %h", k, obs, e);
            end
            tick();
        end
        n_cmp++;
        if ({ob_valid, ob_last, ob_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_end_idle: got %b want 001", {ob_valid, ob_last, ob_ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        logic [20:0] e;
        a = 64'hA3A2_A1A0_AFAF_A0A0;
        b = 64'hB3B2_B1B0_BEEF_B0B0;
        data = a; in_valid = 1'b1; out_ready_dn = 1'b1;
        tick();
        data = b;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                in_valid = 1'b0;
                data = 64'h5555_6666_7777_8888;
            end
            #1;
            e = {1'b1, ((c % 4) == 3), ((c % 4) == 3), 2'(c % 4),
                 lane_of((c < 4) ? a : b, c % 4)};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h want %h", c, obs, e);
            end
            tick();
        end
        n_cmp++;
        if ({ob_valid, ob_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_end_idle: got %b want 01", {ob_valid, ob_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] w;
        logic [20:0] e;
        w = 64'h4444_3333_2222_1111;
        data = w; in_valid = 1'b1; out_ready_dn = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready_dn = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            e = {1'b1, 1'b0, 1'b0, 2'd1, lane_of(w, 1)};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got %h want %h", c, obs, e);
            end
            tick();
        end
        out_ready_dn = 1'b1;
        #1;
        e = {1'b1, 1'b0, 1'b0, 2'd1, lane_of(w, 1)};
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL bp_resume1: got %h want %h", obs, e);
        end
        tick();
        e = {1'b1, 1'b0, 1'b0, 2'd2, lane_of(w, 2)};
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL bp_resume2: got %h want %h", obs, e);
        end
        tick();
        out_ready_dn = 1'b0;
        #1;
        e = {1'b1, 1'b1, 1'b0, 2'd3, lane_of(w, 3)};
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL bp_last_stalled: got %h want %h", obs, e);
        end
        tick();
        out_ready_dn = 1'b1;
        #1;
        e = {1'b1, 1'b1, 1'b1, 2'd3, lane_of(w, 3)};
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL bp_last_ready: got %h want %h", obs, e);
        end
        tick();
        n_cmp++;
        if ({ob_valid, ob_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_end_idle: got %b want 01", {ob_valid, ob_ready});
        end
    endtask

    task automatic test_reset_mid_word();
        logic [63:0] w, n;
        logic [20:0] e;
        w = 64'h4444_3333_2222_1111;
        n = 64'hDDDD_CCCC_BBBB_AAAA;
        data = w; in_valid = 1'b1; out_ready_dn = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        e = {1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        n_cmp++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL rst_mid_async: got %h want %h", obs, e);
        end
        tick();
        rst_n = 1'b1;
        data = n; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = {1'b1, (k == 3), (k == 3), 2'(k), lane_of(n, k)};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL rst_mid_lane%0d: got %h want %h", k, obs, e);
            end
            tick();
        end
    endtask

    task automatic test_input_ignored();
        logic [63:0] w;
        logic [20:0] e;
        w = 64'h0123_4567_89AB_CDEF;
        data = w; in_valid = 1'b1; out_ready_dn = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            data = 64'hFFFF_0000_FFFF_0000 ^ {4{16'(k * 16'h1357)}};
            if (k == 3) in_valid = 1'b0;
            #1;
            e = {1'b1, (k == 3), (k == 3), 2'(k), lane_of(w, k)};
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL ignore_lane%0d: got %h want %h", k, obs, e);
            end
            tick();
        end
        n_cmp++;
        if ({ob_valid, ob_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL ignore_end_idle: got %b want 01", {ob_valid, ob_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_input_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
